// File: rtl/stack_unit_pkg.sv
// Shared definitions for the operand stack: default geometry, the per-cycle
// operation encoding and the strobe decoder used by the stack and its users.
package stack_unit_pkg;

  localparam int WORD_W_DEF = 8;
  localparam int DEPTH_DEF  = 16;

  // What the stack does in a given cycle; there is no multi-cycle state.
  typedef enum logic [2:0] {
    OP_IDLE,
    OP_PUSH,
    OP_POP,
    OP_PEEK,
    OP_REPLACE
  } stack_op_e;

  // Map the controller strobes plus current status onto one operation.
  // Error side effects (ovf/unf) are derived separately from the raw strobes.
  function automatic stack_op_e decode_op(input logic push,
                                          input logic pop,
                                          input logic tos,
                                          input logic empty,
                                          input logic full);
    stack_op_e op;
    op = OP_IDLE;
    if (push && pop) begin
      // Replace top; on an empty stack the push still goes through.
      op = empty ? OP_PUSH : OP_REPLACE;
    end else if (pop) begin
      // tos alongside pop is just a pop.
      op = empty ? OP_IDLE : OP_POP;
    end else if (push) begin
      // A rejected push with tos still shows the existing top.
      if (full) op = tos ? OP_PEEK : OP_IDLE;
      else      op = OP_PUSH;
    end else if (tos) begin
      op = OP_PEEK;
    end
    return op;
  endfunction

endpackage

// File: rtl/stack_unit_if.sv
// Controller-to-stack bundle: strobes and push data one way, read data and
// status the other way.
interface stack_unit_if
  import stack_unit_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
);
  localparam int PTR_W = $clog2(DEPTH) + 1;

  logic              push;
  logic              pop;
  logic              tos;
  logic [WORD_W-1:0] din;
  logic              err_clr;
  logic [WORD_W-1:0] dout;
  logic              top_zero;
  logic [PTR_W-1:0]  count;
  logic              empty;
  logic              full;
  logic              ovf;
  logic              unf;

  modport master (
    output push, pop, tos, din, err_clr,
    input  dout, top_zero, count, empty, full, ovf, unf
  );

  modport slave (
    input  push, pop, tos, din, err_clr,
    output dout, top_zero, count, empty, full, ovf, unf
  );
endinterface

// File: rtl/stack_unit_regfile.sv
// Stack storage: one register per entry, single synchronous write port and a
// combinational read port. Contents are deliberately not reset.
module stack_unit_regfile #(
  parameter int WORD_W = 8,
  parameter int DEPTH  = 16,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WORD_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WORD_W-1:0] rd_data
);

  logic [WORD_W-1:0] rows [DEPTH];

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [WORD_W-1:0] entry_reg;

      // Capture write data when this entry is addressed.
      always_ff @(posedge clk) begin
        if (we && wr_addr == ADDR_W'(gi)) entry_reg <= wr_data;
      end

      assign rows[gi] = entry_reg;
    end
  endgenerate

  assign rd_data = rows[rd_addr];

endmodule

// File: rtl/stack_unit.sv
// Operand stack for the stack-machine datapath: decodes the controller's
// push/pop/tos strobes, keeps the entry count, the registered read word and
// the sticky overflow/underflow flags.
module stack_unit
  import stack_unit_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic         clk,
  input  logic         rst,
  stack_unit_if.slave  bus
);

  localparam int PTR_W  = $clog2(DEPTH) + 1;
  localparam int ADDR_W = $clog2(DEPTH);

  logic [PTR_W-1:0]  count_reg, count_next;
  logic [WORD_W-1:0] dout_reg, dout_next;
  logic              ovf_reg, ovf_next;
  logic              unf_reg, unf_next;

  logic              empty;
  logic              full;
  stack_op_e         op;
  logic [ADDR_W-1:0] top_addr;
  logic [WORD_W-1:0] rd_data;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;

  assign empty = (count_reg == '0);
  assign full  = (count_reg == PTR_W'(DEPTH));
  assign op    = decode_op(bus.push, bus.pop, bus.tos, empty, full);

  // Low address bits minus one: wraps to DEPTH-1 when the stack is full.
  assign top_addr = count_reg[ADDR_W-1:0] - ADDR_W'(1);

  stack_unit_regfile #(
    .WORD_W (WORD_W),
    .DEPTH  (DEPTH)
  ) u_regfile (
    .clk     (clk),
    .we      (wr_en),
    .wr_addr (wr_addr),
    .wr_data (bus.din),
    .rd_addr (top_addr),
    .rd_data (rd_data)
  );

  // Next-state for count, read word, storage write and sticky flags.
  always_comb begin
    count_next = count_reg;
    dout_next  = dout_reg;
    wr_en      = 1'b0;
    wr_addr    = top_addr;
    case (op)
      OP_PUSH: begin
        wr_en      = 1'b1;
        wr_addr    = count_reg[ADDR_W-1:0];
        count_next = count_reg + PTR_W'(1);
        // A peek issued with a lone push returns the word being pushed.
        if (bus.tos && !bus.pop) dout_next = bus.din;
      end
      OP_POP: begin
        dout_next  = rd_data;
        count_next = count_reg - PTR_W'(1);
      end
      OP_PEEK: begin
        dout_next = empty ? '0 : rd_data;
      end
      OP_REPLACE: begin
        dout_next = rd_data;
        wr_en     = 1'b1;
      end
      default: ;
    endcase
    // A fresh error in the same cycle as err_clr keeps the flag set.
    ovf_next = (bus.push && !bus.pop && full) || (ovf_reg && !bus.err_clr);
    unf_next = (bus.pop && empty) || (unf_reg && !bus.err_clr);
  end

  // State registers; reset overrides every strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= '0;
      dout_reg  <= '0;
      ovf_reg   <= 1'b0;
      unf_reg   <= 1'b0;
    end else begin
      count_reg <= count_next;
      dout_reg  <= dout_next;
      ovf_reg   <= ovf_next;
      unf_reg   <= unf_next;
    end
  end

  assign bus.dout     = dout_reg;
  assign bus.count    = count_reg;
  assign bus.empty    = empty;
  assign bus.full     = full;
  assign bus.ovf      = ovf_reg;
  assign bus.unf      = unf_reg;
  assign bus.top_zero = !empty && (rd_data == '0);

endmodule

// File: tb/tb_stack_unit.sv
// Directed bench for stack_unit: each driven cycle queues its hand-computed
// expected state; a monitor pops and compares just after the clock edge.
module tb_stack_unit;

  logic clk;
  logic rst;

  stack_unit_if #(.WORD_W(8), .DEPTH(16)) bus ();

  stack_unit #(.WORD_W(8), .DEPTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    string      name;
    logic [7:0] dout;
    logic [4:0] count;
    logic [4:0] flags;   // {empty, full, ovf, unf, top_zero}
    bit         chk_dout;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string tag, input string what,
                     input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s %s: got %0h, expected %0h", tag, what, act, exp);
    end
  endtask

  // Drive one cycle of strobes and queue the state expected after its edge.
  task automatic step(input string name, input logic r, input logic pu,
                      input logic po, input logic t, input logic clr,
                      input logic [7:0] d, input int cnt, input logic e_ovf,
                      input logic e_unf, input logic e_tz, input bit chk_d,
                      input logic [7:0] e_dout);
    exp_t e;
    @(negedge clk);
    rst         = r;
    bus.push    = pu;
    bus.pop     = po;
    bus.tos     = t;
    bus.err_clr = clr;
    bus.din     = d;
    e.name      = name;
    e.dout      = e_dout;
    e.count     = 5'(cnt);
    e.flags     = {cnt == 0, cnt == 16, e_ovf, e_unf, e_tz};
    e.chk_dout  = chk_d;
    q.push_back(e);
  endtask

  // Monitor: compare DUT state against the oldest queued expectation.
  initial begin
    exp_t m;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        m = q.pop_front();
        $display("[TB] %s: count=%0d dout=%02h flags=%b", m.name, bus.count,
                 bus.dout, {bus.empty, bus.full, bus.ovf, bus.unf, bus.top_zero});
        cmp(m.name, "count", 8'(bus.count), 8'(m.count));
        cmp(m.name, "flags{empty,full,ovf,unf,top_zero}",
            8'({bus.empty, bus.full, bus.ovf, bus.unf, bus.top_zero}), 8'(m.flags));
        if (m.chk_dout) cmp(m.name, "dout", bus.dout, m.dout);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; bus.push = 1'b0; bus.pop = 1'b0; bus.tos = 1'b0;
    bus.err_clr = 1'b0; bus.din = 8'h00;

    //    name        rst pu po t clr din    cnt ovf unf tz chk dout
    step("reset",      1, 0, 0, 0, 0, 8'h00, 0,  0, 0, 0, 1, 8'h00);
    step("push11",     0, 1, 0, 0, 0, 8'h11, 1,  0, 0, 0, 0, 8'h00);
    step("push22",     0, 1, 0, 0, 0, 8'h22, 2,  0, 0, 0, 0, 8'h00);
    step("push33",     0, 1, 0, 0, 0, 8'h33, 3,  0, 0, 0, 0, 8'h00);
    step("tos33",      0, 0, 0, 1, 0, 8'h00, 3,  0, 0, 0, 1, 8'h33);
    step("pop33",      0, 0, 1, 0, 0, 8'h00, 2,  0, 0, 0, 1, 8'h33);
    step("pop22",      0, 0, 1, 0, 0, 8'h00, 1,  0, 0, 0, 1, 8'h22);
    step("pop11",      0, 0, 1, 0, 0, 8'h00, 0,  0, 0, 0, 1, 8'h11);
    step("pop_empty",  0, 0, 1, 0, 0, 8'h00, 0,  0, 1, 0, 1, 8'h11);
    step("clr_unf",    0, 0, 0, 0, 1, 8'h00, 0,  0, 0, 0, 1, 8'h11);
    step("tos_empty",  0, 0, 0, 1, 0, 8'h00, 0,  0, 0, 0, 1, 8'h00);
    for (int i = 0; i < 16; i++)
      step($sformatf("fill%0d", i), 0, 1, 0, 0, 0, 8'(i), i + 1, 0, 0, i == 0, 0, 8'h00);
    step("push_full",  0, 1, 0, 0, 0, 8'hAA, 16, 1, 0, 0, 0, 8'h00);
    step("tos_full",   0, 0, 0, 1, 0, 8'h00, 16, 1, 0, 0, 1, 8'h0F);
    step("ovf_vs_clr", 0, 1, 0, 0, 1, 8'hBB, 16, 1, 0, 0, 1, 8'h0F);
    step("clr_ovf",    0, 0, 0, 0, 1, 8'h00, 16, 0, 0, 0, 1, 8'h0F);
    step("repl_full",  0, 1, 1, 0, 0, 8'h77, 16, 0, 0, 0, 1, 8'h0F);
    step("tos77",      0, 0, 0, 1, 0, 8'h00, 16, 0, 0, 0, 1, 8'h77);
    step("tospush_ful",0, 1, 0, 1, 0, 8'h55, 16, 1, 0, 0, 1, 8'h77);
    step("reset2",     1, 0, 0, 0, 0, 8'h00, 0,  0, 0, 0, 1, 8'h00);
    step("pop_empty2", 0, 0, 1, 0, 0, 8'h00, 0,  0, 1, 0, 1, 8'h00);
    for (int i = 1; i <= 5; i++)
      step($sformatf("push0%0d", i), 0, 1, 0, 0, 0, 8'(i), i, 0, 1, 0, 0, 8'h00);
    step("rst_w_push", 1, 1, 0, 0, 0, 8'h44, 0,  0, 0, 0, 1, 8'h00);
    step("push44",     0, 1, 0, 0, 0, 8'h44, 1,  0, 0, 0, 1, 8'h00);
    step("tos44",      0, 0, 0, 1, 0, 8'h00, 1,  0, 0, 0, 1, 8'h44);
    step("reset3",     1, 0, 0, 0, 0, 8'h00, 0,  0, 0, 0, 1, 8'h00);
    step("push05",     0, 1, 0, 0, 0, 8'h05, 1,  0, 0, 0, 0, 8'h00);
    step("push07",     0, 1, 0, 0, 0, 8'h07, 2,  0, 0, 0, 0, 8'h00);
    step("replace0C",  0, 1, 1, 0, 0, 8'h0C, 2,  0, 0, 0, 1, 8'h07);
    step("tos0C",      0, 0, 0, 1, 0, 8'h00, 2,  0, 0, 0, 1, 8'h0C);
    step("push00",     0, 1, 0, 0, 0, 8'h00, 3,  0, 0, 1, 1, 8'h0C);
    step("push01",     0, 1, 0, 0, 0, 8'h01, 4,  0, 0, 0, 1, 8'h0C);
    step("pop01",      0, 0, 1, 0, 0, 8'h00, 3,  0, 0, 1, 1, 8'h01);
    step("pop00",      0, 0, 1, 0, 0, 8'h00, 2,  0, 0, 0, 1, 8'h00);
    step("pop0C",      0, 0, 1, 0, 0, 8'h00, 1,  0, 0, 0, 1, 8'h0C);
    step("pop05",      0, 0, 1, 0, 0, 8'h00, 0,  0, 0, 0, 1, 8'h05);
    step("repl_empty", 0, 1, 1, 0, 0, 8'h09, 1,  0, 1, 0, 1, 8'h05);
    step("tospush00",  0, 1, 0, 1, 0, 8'h00, 2,  0, 1, 1, 1, 8'h00);
    step("poptos",     0, 0, 1, 1, 0, 8'h00, 1,  0, 1, 0, 1, 8'h00);

    @(negedge clk);
    bus.push = 1'b0; bus.pop = 1'b0; bus.tos = 1'b0; bus.err_clr = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("[TB] FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
